huff_sort: RTL

- Downstream stage of the symbol-frequency counter in the Huffman encoder.
- On the counter's end flag, captures the six 8-bit symbol counts and sorts them in descending count order, carrying the symbol IDs along.
- Sorting is a multi-cycle odd-even transposition sort.
- The ranked list plus a non-zero-symbol count feeds the Huffman tree-combine stage.

---
 rtl/huff_pkg.sv | 28 ++
 rtl/huff_cmp_swap.sv | 26 ++
 rtl/huff_sort.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/huff_pkg.sv
// Shared types and constants for the Huffman rank/sort stage.
// State encoding, widths and the non-zero popcount helper.
package huff_pkg;

  localparam int CNT_W  = 8;
  localparam int NSYM   = 6;
  localparam int SYM_W  = 3;
  localparam int PASS_W = 3;

  localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(NSYM - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [2:0] nz_count(
    input logic [NSYM*CNT_W-1:0] c
  );
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < NSYM; i++)
      n = n + {2'b00, |c[i*CNT_W +: CNT_W]};
    return n;
  endfunction

endpackage

// File: rtl/huff_cmp_swap.sv
// One compare-exchange cell: higher count first,
// ties broken by the lower symbol ID.
module huff_cmp_swap
  import huff_pkg::*;
(
  input  logic [SYM_W-1:0] a_sym,
  input  logic [CNT_W-1:0] a_cnt,
  input  logic [SYM_W-1:0] b_sym,
  input  logic [CNT_W-1:0] b_cnt,
  output logic [SYM_W-1:0] h_sym,
  output logic [CNT_W-1:0] h_cnt,
  output logic [SYM_W-1:0] l_sym,
  output logic [CNT_W-1:0] l_cnt
);

  logic swap;

  assign swap = (a_cnt < b_cnt) ||
                ((a_cnt == b_cnt) && (a_sym > b_sym));

  assign h_sym = swap ? b_sym : a_sym;
  assign h_cnt = swap ? b_cnt : a_cnt;
  assign l_sym = swap ? a_sym : b_sym;
  assign l_cnt = swap ? a_cnt : b_cnt;

endmodule

// File: rtl/huff_sort.sv
// Captures six symbol counts on the counter's end edge and ranks
// them with a six-pass odd-even transposition sort.
module huff_sort
  import huff_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             CNT_end,
  input  logic [CNT_W-1:0] CNT1,
  input  logic [CNT_W-1:0] CNT2,
  input  logic [CNT_W-1:0] CNT3,
  input  logic [CNT_W-1:0] CNT4,
  input  logic [CNT_W-1:0] CNT5,
  input  logic [CNT_W-1:0] CNT6,
  output logic [SYM_W-1:0] SYM1,
  output logic [SYM_W-1:0] SYM2,
  output logic [SYM_W-1:0] SYM3,
  output logic [SYM_W-1:0] SYM4,
  output logic [SYM_W-1:0] SYM5,
  output logic [SYM_W-1:0] SYM6,
  output logic [CNT_W-1:0] FRQ1,
  output logic [CNT_W-1:0] FRQ2,
  output logic [CNT_W-1:0] FRQ3,
  output logic [CNT_W-1:0] FRQ4,
  output logic [CNT_W-1:0] FRQ5,
  output logic [CNT_W-1:0] FRQ6,
  output logic [2:0]       sym_num,
  output logic             sort_done
);

  state_t            state;
  logic              cnt_end_q;
  logic [PASS_W-1:0] pass;
  logic [2:0]        nz_q;
  logic              odd;

  logic [CNT_W-1:0] cin   [NSYM];
  logic [SYM_W-1:0] w_sym [NSYM];
  logic [CNT_W-1:0] w_cnt [NSYM];
  logic [SYM_W-1:0] n_sym [NSYM];
  logic [CNT_W-1:0] n_cnt [NSYM];
  logic [SYM_W-1:0] o_sym [NSYM];
  logic [CNT_W-1:0] o_cnt [NSYM];

  logic [SYM_W-1:0] a_sym [3];
  logic [CNT_W-1:0] a_cnt [3];
  logic [SYM_W-1:0] b_sym [3];
  logic [CNT_W-1:0] b_cnt [3];
  logic [SYM_W-1:0] h_sym [3];
  logic [CNT_W-1:0] h_cnt [3];
  logic [SYM_W-1:0] l_sym [3];
  logic [CNT_W-1:0] l_cnt [3];

  assign cin[0] = CNT1;
  assign cin[1] = CNT2;
  assign cin[2] = CNT3;
  assign cin[3] = CNT4;
  assign cin[4] = CNT5;
  assign cin[5] = CNT6;

  assign odd = pass[0];

  // Cell 2 only matters on even passes; on odd passes 0 and 5 sit out.
  always_comb begin
    a_sym[0] = odd ? w_sym[1] : w_sym[0];
    a_cnt[0] = odd ? w_cnt[1] : w_cnt[0];
    b_sym[0] = odd ? w_sym[2] : w_sym[1];
    b_cnt[0] = odd ? w_cnt[2] : w_cnt[1];
    a_sym[1] = odd ? w_sym[3] : w_sym[2];
    a_cnt[1] = odd ? w_cnt[3] : w_cnt[2];
    b_sym[1] = odd ? w_sym[4] : w_sym[3];
    b_cnt[1] = odd ? w_cnt[4] : w_cnt[3];
    a_sym[2] = w_sym[4];
    a_cnt[2] = w_cnt[4];
    b_sym[2] = w_sym[5];
    b_cnt[2] = w_cnt[5];
  end

  for (genvar g = 0; g < 3; g++) begin : g_cs
    huff_cmp_swap u_cs (
      .a_sym (a_sym[g]),
      .a_cnt (a_cnt[g]),
      .b_sym (b_sym[g]),
      .b_cnt (b_cnt[g]),
      .h_sym (h_sym[g]),
      .h_cnt (h_cnt[g]),
      .l_sym (l_sym[g]),
      .l_cnt (l_cnt[g])
    );
  end

  always_comb begin
    for (int i = 0; i < NSYM; i++) begin
      n_sym[i] = w_sym[i];
      n_cnt[i] = w_cnt[i];
    end
    if (odd) begin
      n_sym[1] = h_sym[0]; n_cnt[1] = h_cnt[0];
      n_sym[2] = l_sym[0]; n_cnt[2] = l_cnt[0];
      n_sym[3] = h_sym[1]; n_cnt[3] = h_cnt[1];
      n_sym[4] = l_sym[1]; n_cnt[4] = l_cnt[1];
    end else begin
      n_sym[0] = h_sym[0]; n_cnt[0] = h_cnt[0];
      n_sym[1] = l_sym[0]; n_cnt[1] = l_cnt[0];
      n_sym[2] = h_sym[1]; n_cnt[2] = h_cnt[1];
      n_sym[3] = l_sym[1]; n_cnt[3] = l_cnt[1];
      n_sym[4] = h_sym[2]; n_cnt[4] = h_cnt[2];
      n_sym[5] = l_sym[2]; n_cnt[5] = l_cnt[2];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt_end_q <= 1'b0;
      pass      <= '0;
      nz_q      <= '0;
      sym_num   <= '0;
      sort_done <= 1'b0;
      for (int i = 0; i < NSYM; i++) begin
        w_sym[i] <= '0;
        w_cnt[i] <= '0;
        o_sym[i] <= '0;
        o_cnt[i] <= '0;
      end
    end else begin
      cnt_end_q <= CNT_end;
      case (state)
        IDLE: begin
          if (CNT_end && !cnt_end_q) begin
            for (int i = 0; i < NSYM; i++) begin
              w_sym[i] <= SYM_W'(i + 1);
              w_cnt[i] <= cin[i];
            end
            nz_q  <= nz_count({CNT6, CNT5, CNT4,
                               CNT3, CNT2, CNT1});
            pass  <= '0;
            state <= SORT;
          end
        end
        SORT: begin
          for (int i = 0; i < NSYM; i++) begin
            w_sym[i] <= n_sym[i];
            w_cnt[i] <= n_cnt[i];
          end
          if (pass == LAST_PASS) begin
            for (int i = 0; i < NSYM; i++) begin
              o_sym[i] <= n_sym[i];
              o_cnt[i] <= n_cnt[i];
            end
            sym_num   <= nz_q;
            sort_done <= 1'b1;
            state     <= DONE;
          end else begin
            pass <= pass + 1'b1;
          end
        end
        DONE: ;
        default: state <= IDLE;
      endcase
    end
  end

  assign SYM1 = o_sym[0];
  assign SYM2 = o_sym[1];
  assign SYM3 = o_sym[2];
  assign SYM4 = o_sym[3];
  assign SYM5 = o_sym[4];
  assign SYM6 = o_sym[5];
  assign FRQ1 = o_cnt[0];
  assign FRQ2 = o_cnt[1];
  assign FRQ3 = o_cnt[2];
  assign FRQ4 = o_cnt[3];
  assign FRQ5 = o_cnt[4];
  assign FRQ6 = o_cnt[5];

endmodule
